// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM-stage exception arbiter: ExcCodes, mem_exc_i
// bit positions and the arbiter state type.
package exc_pkg;

  localparam int unsigned INT_W = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // mem_exc_i = {eret, ades, adel_d, bp, sys, ov, ri, adel_f}
  localparam int unsigned EB_ADEL_F = 0;
  localparam int unsigned EB_RI     = 1;
  localparam int unsigned EB_OV     = 2;
  localparam int unsigned EB_SYS    = 3;
  localparam int unsigned EB_BP     = 4;
  localparam int unsigned EB_ADEL_D = 5;
  localparam int unsigned EB_ADES   = 6;
  localparam int unsigned EB_ERET   = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchroniser for the asynchronous external interrupt lines.
module int_sync
  import exc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] d,
  output logic [INT_W-1:0] q
);

  logic [INT_W-1:0] r_meta;
  logic [INT_W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter between MEM and CP0: prioritises events, drives
// the CP0 exception-write port, pipeline flush and redirect PC.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VEC      = 32'h8000_0180,
  parameter logic [31:0] EXC_VEC_BEV  = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [7:0]  mem_exc_i,
  input  logic [31:0] mem_badvaddr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        exc_we_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        badvaddr_we_o,
  output logic [31:0] badvaddr_o,
  output logic        eret_o
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic        r_exc_we;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic        r_bd;
  logic        r_bv_we;
  logic [31:0] r_bva;
  logic        r_eret;

  logic        w_irq;
  logic        w_exc;
  logic        w_eret;
  logic        w_take;
  logic [4:0]  w_code;
  logic        w_bv_we;
  logic [31:0] w_bva;
  logic [31:0] w_epc;
  logic [31:0] w_vec;
  logic        w_unused;

  assign w_unused = ^{status_i[31:23], status_i[21:16], status_i[7:2],
                      cause_i[31:16], cause_i[7:0]};

  int_sync u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (int_sync_o)
  );

  assign w_irq = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign w_epc = mem_in_ds_i ? (mem_pc_i - 32'd4) : mem_pc_i;
  assign w_vec = status_i[22] ? EXC_VEC_BEV : EXC_VEC;

  always_comb begin
    w_exc   = 1'b1;
    w_eret  = 1'b0;
    w_code  = EXC_INT;
    w_bv_we = 1'b0;
    w_bva   = mem_badvaddr_i;
    w_next  = r_state;
    if (w_irq) begin
      w_code = EXC_INT;
    end else if (mem_exc_i[EB_ADEL_F]) begin
      w_code  = EXC_ADEL;
      w_bv_we = 1'b1;
      w_bva   = mem_pc_i;
    end else if (mem_exc_i[EB_RI]) begin
      w_code = EXC_RI;
    end else if (mem_exc_i[EB_OV]) begin
      w_code = EXC_OV;
    end else if (mem_exc_i[EB_SYS]) begin
      w_code = EXC_SYS;
    end else if (mem_exc_i[EB_BP]) begin
      w_code = EXC_BP;
    end else if (mem_exc_i[EB_ADEL_D]) begin
      w_code  = EXC_ADEL;
      w_bv_we = 1'b1;
    end else if (mem_exc_i[EB_ADES]) begin
      w_code  = EXC_ADES;
      w_bv_we = 1'b1;
    end else begin
      w_exc  = 1'b0;
      w_eret = mem_exc_i[EB_ERET];
    end
    w_take = (r_state == IDLE) & mem_valid_i & (w_exc | w_eret);
    case (r_state)
      IDLE:    if (w_take) w_next = FLUSH;
      FLUSH:   if (r_cnt == 4'd0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_exc_we <= 1'b0;
      r_code   <= '0;
      r_epc    <= '0;
      r_bd     <= 1'b0;
      r_bv_we  <= 1'b0;
      r_bva    <= '0;
      r_eret   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_exc_we <= 1'b0;
      r_bv_we  <= 1'b0;
      r_eret   <= 1'b0;
      if (w_take) begin
        // Counter is loaded with N-1 so flush_o spans exactly FLUSH_CYCLES cycles.
        r_flush <= 1'b1;
        r_cnt   <= 4'(FLUSH_CYCLES - 1);
        if (w_exc) begin
          r_exc_we <= 1'b1;
          r_code   <= w_code;
          r_epc    <= w_epc;
          r_bd     <= mem_in_ds_i;
          r_new_pc <= w_vec;
          r_bv_we  <= w_bv_we;
          if (w_bv_we) r_bva <= w_bva;
        end else begin
          r_eret   <= 1'b1;
          r_new_pc <= epc_i;
        end
      end else if (r_state == FLUSH) begin
        if (r_cnt == 4'd0) r_flush <= 1'b0;
        else               r_cnt   <= r_cnt - 4'd1;
      end
    end
  end

  assign flush_o       = r_flush;
  assign new_pc_o      = r_new_pc;
  assign exc_we_o      = r_exc_we;
  assign exc_code_o    = r_code;
  assign exc_epc_o     = r_epc;
  assign exc_bd_o      = r_bd;
  assign badvaddr_we_o = r_bv_we;
  assign badvaddr_o    = r_bva;
  assign eret_o        = r_eret;

endmodule
